// File: rtl/cache_mem_arbiter_pkg.sv
// Shared state and grant-source encodings for the I/D cache memory arbiter.
// No logic; the helper sizes the I-burst beat counter.
// Shared by the arbiter top and its port steering mux.
package cache_arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GNT_I = 2'd1;
  localparam logic [1:0] ARB_GNT_D = 2'd2;

  localparam logic GNT_SRC_I = 1'b0;
  localparam logic GNT_SRC_D = 1'b1;

  // A single-beat burst still needs a 1-bit counter.
  function automatic int beat_cnt_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_mux.sv
// Steers the shared memory port and the ready/data returns to the granted side.
// Purely combinational; zero latency from state and inputs.
// Backpressure passes straight through: mem_ready reaches only the owner.
module cache_mem_mux
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            state,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic                  i_mem_read_en,
  output logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  i_mem_ready,
  input  logic [ADDR_WIDTH-1:0] d_mem_addr,
  input  logic [DATA_WIDTH-1:0] d_mem_write_data,
  input  logic                  d_mem_read_en,
  input  logic                  d_mem_write_en,
  output logic [DATA_WIDTH-1:0] d_mem_read_data,
  output logic                  d_mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ready
);

  always_comb begin
    mem_addr        = '0;
    mem_write_data  = '0;
    mem_read_en     = 1'b0;
    mem_write_en    = 1'b0;
    i_mem_read_data = '0;
    i_mem_ready     = 1'b0;
    d_mem_read_data = '0;
    d_mem_ready     = 1'b0;
    case (state)
      ARB_GNT_I: begin
        // Following the enable lets an abort cycle drop the strobe at once.
        mem_addr        = i_mem_addr;
        mem_read_en     = i_mem_read_en;
        i_mem_ready     = mem_ready;
        i_mem_read_data = mem_read_data;
      end
      ARB_GNT_D: begin
        mem_addr        = d_mem_addr;
        mem_write_data  = d_mem_write_data;
        mem_write_en    = d_mem_write_en;
        mem_read_en     = d_mem_read_en & ~d_mem_write_en;
        d_mem_ready     = mem_ready;
        d_mem_read_data = mem_read_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and D-cache accesses.
// Grant one cycle after the request is seen in IDLE; one IDLE cycle between transactions.
// The owner is held for its whole transaction; memory stalls hold state and beat count.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int I_BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic                  i_mem_read_en,
  output logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  i_mem_ready,
  input  logic [ADDR_WIDTH-1:0] d_mem_addr,
  input  logic [DATA_WIDTH-1:0] d_mem_write_data,
  input  logic                  d_mem_read_en,
  input  logic                  d_mem_write_en,
  output logic [DATA_WIDTH-1:0] d_mem_read_data,
  output logic                  d_mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ready,
  output logic                  grant_i,
  output logic                  grant_d,
  output logic [31:0]           i_grant_count,
  output logic [31:0]           d_grant_count
);

  localparam int            BW        = beat_cnt_width(I_BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(I_BURST_LEN - 1);

  logic [1:0]    state;
  logic [BW-1:0] beat_cnt;
  logic          last_grant;
  logic          i_req;
  logic          d_req;

  assign i_req = i_mem_read_en;
  assign d_req = d_mem_read_en | d_mem_write_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB_IDLE;
      beat_cnt      <= '0;
      last_grant    <= GNT_SRC_I;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          // On a tie the side that did not win last time goes first.
          if (i_req && (!d_req || last_grant == GNT_SRC_D)) begin
            state         <= ARB_GNT_I;
            beat_cnt      <= '0;
            last_grant    <= GNT_SRC_I;
            i_grant_count <= i_grant_count + 32'd1;
          end else if (d_req) begin
            state         <= ARB_GNT_D;
            beat_cnt      <= '0;
            last_grant    <= GNT_SRC_D;
            d_grant_count <= d_grant_count + 32'd1;
          end
        end
        ARB_GNT_I: begin
          if (!i_req) begin
            state <= ARB_IDLE;
          end else if (mem_ready) begin
            if (beat_cnt == LAST_BEAT) state <= ARB_IDLE;
            else                       beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ARB_GNT_D: begin
          if (!d_req || mem_ready) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign grant_i = (state == ARB_GNT_I);
  assign grant_d = (state == ARB_GNT_D);

  cache_mem_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .state            (state),
    .i_mem_addr       (i_mem_addr),
    .i_mem_read_en    (i_mem_read_en),
    .i_mem_read_data  (i_mem_read_data),
    .i_mem_ready      (i_mem_ready),
    .d_mem_addr       (d_mem_addr),
    .d_mem_write_data (d_mem_write_data),
    .d_mem_read_en    (d_mem_read_en),
    .d_mem_write_en   (d_mem_write_en),
    .d_mem_read_data  (d_mem_read_data),
    .d_mem_ready      (d_mem_ready),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_en      (mem_read_en),
    .mem_write_en     (mem_write_en),
    .mem_read_data    (mem_read_data),
    .mem_ready        (mem_ready)
  );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized checks of the I/D memory arbiter against a transaction-level model.
// The model tracks only who should win next and how many grants each side has received.
module tb_cache_mem_arbiter;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_mem_addr = '0, d_mem_addr = '0, d_mem_write_data = '0, mem_read_data = '0;
  logic        i_mem_read_en = 1'b0, d_mem_read_en = 1'b0, d_mem_write_en = 1'b0, mem_ready = 1'b0;
  logic [31:0] i_mem_read_data, d_mem_read_data, mem_addr, mem_write_data;
  logic        i_mem_ready, d_mem_ready, mem_read_en, mem_write_en, grant_i, grant_d;
  logic [31:0] i_grant_count, d_grant_count;

  int n_cmp = 0;
  int n_err = 0;
  int m_icnt = 0;
  int m_dcnt = 0;
  bit m_last = 1'b0;      // side that won last: 0 = I, 1 = D
  logic p_rd = 1'b0, p_wr = 1'b0;

  cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .I_BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .i_mem_addr(i_mem_addr), .i_mem_read_en(i_mem_read_en),
    .i_mem_read_data(i_mem_read_data), .i_mem_ready(i_mem_ready),
    .d_mem_addr(d_mem_addr), .d_mem_write_data(d_mem_write_data),
    .d_mem_read_en(d_mem_read_en), .d_mem_write_en(d_mem_write_en),
    .d_mem_read_data(d_mem_read_data), .d_mem_ready(d_mem_ready),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .grant_i(grant_i), .grant_d(grant_d),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grants"}, 32'({grant_i, grant_d}), 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, ".strobes"}, 32'({mem_read_en, mem_write_en, i_mem_ready, d_mem_ready}), 32'd0);
    chk({tag, ".rdata"}, i_mem_read_data | d_mem_read_data, 32'd0);
  endtask

  // Memory may raise ready while idle; nothing must reach either side.
  task automatic idle_cycle(input string tag);
    mem_ready     = 1'($urandom);
    mem_read_data = $urandom;
    @(negedge clk);
    chk_all_zero(tag);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".icnt"}, i_grant_count, 32'(m_icnt));
    chk({tag, ".dcnt"}, d_grant_count, 32'(m_dcnt));
  endtask

  // Caller holds i_mem_read_en; the grant is expected from the next cycle on.
  task automatic serve_i(input string tag, input logic [31:0] base, input logic [31:0] dbase,
                         input int stall_beat, input int stall_len, input int d_after,
                         input int abort_after);
    int b = 0;
    int s = 0;
    m_icnt++;
    m_last = 1'b0;
    while (b < BL) begin
      tick();
      if (d_after >= 0 && b >= d_after) begin
        d_mem_read_en  = p_rd;
        d_mem_write_en = p_wr;
      end
      if (abort_after >= 0 && b == abort_after) begin
        i_mem_read_en = 1'b0;
        mem_ready     = 1'($urandom);
        mem_read_data = $urandom;
        @(negedge clk);
        chk({tag, ".abort_gnt"}, 32'(grant_i), 32'd1);
        chk({tag, ".abort_rd"}, 32'(mem_read_en), 32'd0);
        chk({tag, ".abort_dready"}, 32'(d_mem_ready), 32'd0);
        return;
      end
      i_mem_addr    = base + 32'(4 * b);
      mem_ready     = (b == stall_beat && s < stall_len) ? 1'b0 : 1'b1;
      mem_read_data = dbase + 32'(b);
      @(negedge clk);
      chk({tag, ".grants"}, 32'({grant_i, grant_d}), 32'd2);
      chk({tag, ".mem_addr"}, mem_addr, base + 32'(4 * b));
      chk({tag, ".strobes"}, 32'({mem_read_en, mem_write_en}), 32'd2);
      chk({tag, ".mem_wdata"}, mem_write_data, 32'd0);
      chk({tag, ".iready"}, 32'(i_mem_ready), (b == stall_beat && s < stall_len) ? 32'd0 : 32'd1);
      chk({tag, ".irdata"}, i_mem_read_data, dbase + 32'(b));
      chk({tag, ".d_quiet"}, 32'(d_mem_ready) | d_mem_read_data, 32'd0);
      if (b == stall_beat && s < stall_len) s++;
      else b++;
    end
  endtask

  // Caller holds the D request; the grant is expected from the next cycle on.
  task automatic serve_d(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input int stall_len);
    int s = 0;
    bit done = 1'b0;
    logic [31:0] rdat;
    m_dcnt++;
    m_last = 1'b1;
    while (!done) begin
      tick();
      rdat          = $urandom;
      mem_ready     = (s < stall_len) ? 1'b0 : 1'b1;
      mem_read_data = rdat;
      @(negedge clk);
      chk({tag, ".grants"}, 32'({grant_i, grant_d}), 32'd1);
      chk({tag, ".mem_addr"}, mem_addr, a);
      chk({tag, ".mem_wdata"}, mem_write_data, wd);
      chk({tag, ".strobes"}, 32'({mem_read_en, mem_write_en}), 32'({rd & ~wr, wr}));
      chk({tag, ".dready"}, 32'(d_mem_ready), (s < stall_len) ? 32'd0 : 32'd1);
      chk({tag, ".drdata"}, d_mem_read_data, rdat);
      chk({tag, ".i_quiet"}, 32'(i_mem_ready) | i_mem_read_data, 32'd0);
      if (s < stall_len) s++;
      else done = 1'b1;
    end
  endtask

  initial begin
    int kind;
    int dstall;
    bit first_d;
    logic [31:0] ia, da, wd;
    logic rd, wr;

    // Reset with busy-looking inputs: every output must be 0.
    i_mem_read_en = 1'b1; d_mem_write_en = 1'b1; mem_ready = 1'b1;
    i_mem_addr = 32'h1234; d_mem_addr = 32'h5678; mem_read_data = 32'hFFFF_0000;
    #1 rst = 1'b1;
    #2;
    chk_all_zero("reset");
    chk_counts("reset");
    i_mem_read_en = 1'b0; d_mem_write_en = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // I-only burst with fixed data 0xA0..0xA3.
    tick(); i_mem_read_en = 1'b1; i_mem_addr = 32'h100;
    idle_cycle("t1.req");
    serve_i("t1", 32'h100, 32'hA0, -1, 0, -1, -1);
    tick(); i_mem_read_en = 1'b0;
    idle_cycle("t1.end");
    chk_counts("t1");

    // Tie: I won last, so D goes first, then I after one idle cycle.
    tick();
    i_mem_read_en = 1'b1; i_mem_addr = 32'h200;
    d_mem_addr = 32'h300; d_mem_write_data = 32'hDEADBEEF; d_mem_write_en = 1'b1;
    idle_cycle("t2.req");
    serve_d("t2.d", 32'h300, 32'hDEADBEEF, 1'b0, 1'b1, 0);
    tick(); d_mem_write_en = 1'b0;
    idle_cycle("t2.gap");
    serve_i("t2.i", 32'h200, 32'hB0, -1, 0, -1, -1);
    tick(); i_mem_read_en = 1'b0;
    idle_cycle("t2.end");
    chk_counts("t2");

    // D read arrives after I's first beat and waits for the burst to finish.
    tick(); i_mem_read_en = 1'b1; i_mem_addr = 32'h400;
    d_mem_addr = 32'h500; d_mem_write_data = 32'h0; p_rd = 1'b1; p_wr = 1'b0;
    idle_cycle("t3.req");
    serve_i("t3.i", 32'h400, 32'hC0, -1, 0, 1, -1);
    tick(); i_mem_read_en = 1'b0;
    idle_cycle("t3.gap");
    serve_d("t3.d", 32'h500, 32'h0, 1'b1, 1'b0, 1);
    tick(); d_mem_read_en = 1'b0;
    idle_cycle("t3.end");
    chk_counts("t3");

    // Three stall cycles between beats 2 and 3.
    tick(); i_mem_read_en = 1'b1; i_mem_addr = 32'h600;
    idle_cycle("t4.req");
    serve_i("t4", 32'h600, 32'hD0, 2, 3, -1, -1);
    tick(); i_mem_read_en = 1'b0;
    idle_cycle("t4.end");
    chk_counts("t4");

    // I aborts after beat 1 while a D read+write pair is pending: write wins.
    tick(); i_mem_read_en = 1'b1; i_mem_addr = 32'h800;
    d_mem_addr = 32'h700; d_mem_write_data = 32'h12345678; p_rd = 1'b1; p_wr = 1'b1;
    idle_cycle("t5.req");
    serve_i("t5.i", 32'h800, 32'hE0, -1, 0, 0, 1);
    tick();
    idle_cycle("t5.gap");
    serve_d("t5.d", 32'h700, 32'h12345678, 1'b1, 1'b1, 0);
    tick(); d_mem_read_en = 1'b0; d_mem_write_en = 1'b0;
    idle_cycle("t5.end");
    chk_counts("t5");

    // Reset asserted during beat 2 clears everything without a clock edge.
    tick(); i_mem_read_en = 1'b1; i_mem_addr = 32'h900;
    idle_cycle("t6.req");
    repeat (2) begin
      tick(); mem_ready = 1'b1;
    end
    tick(); mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    m_icnt = 0; m_dcnt = 0; m_last = 1'b0;
    chk_all_zero("t6.rst");
    chk_counts("t6.rst");
    i_mem_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    i_mem_read_en = 1'b1; i_mem_addr = 32'hA00;
    d_mem_read_en = 1'b1; d_mem_addr = 32'hB00; d_mem_write_data = 32'h55;
    idle_cycle("t6.req2");
    serve_d("t6.d", 32'hB00, 32'h55, 1'b1, 1'b0, 0);
    tick(); d_mem_read_en = 1'b0;
    idle_cycle("t6.gap");
    serve_i("t6.i", 32'hA00, 32'hF0, -1, 0, -1, -1);
    tick(); i_mem_read_en = 1'b0;
    idle_cycle("t6.end");
    chk_counts("t6");

    // Randomized rounds: I only, D only, or both at once.
    for (int r = 0; r < 30; r++) begin
      kind   = $urandom_range(1, 3);
      dstall = $urandom_range(0, 2);
      ia     = $urandom & 32'hFFFF_FFF0;
      da     = $urandom;
      wd     = $urandom;
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      tick();
      if (kind != 2) begin
        i_mem_read_en = 1'b1; i_mem_addr = ia;
      end
      if (kind != 1) begin
        d_mem_addr = da; d_mem_write_data = wd; d_mem_read_en = rd; d_mem_write_en = wr;
      end
      first_d = (kind == 2) || (kind == 3 && m_last == 1'b0);
      idle_cycle("rnd.req");
      if (first_d) begin
        serve_d("rnd.d", da, wd, rd, wr, dstall);
        tick(); d_mem_read_en = 1'b0; d_mem_write_en = 1'b0;
        idle_cycle("rnd.gap");
        if (kind == 3) begin
          serve_i("rnd.i", ia, $urandom, $urandom_range(0, BL - 1), $urandom_range(0, 2), -1, -1);
          tick(); i_mem_read_en = 1'b0;
          idle_cycle("rnd.end");
        end
      end else begin
        serve_i("rnd.i", ia, $urandom, $urandom_range(0, BL - 1), $urandom_range(0, 2), -1, -1);
        tick(); i_mem_read_en = 1'b0;
        idle_cycle("rnd.gap");
        if (kind == 3) begin
          serve_d("rnd.d", da, wd, rd, wr, dstall);
          tick(); d_mem_read_en = 1'b0; d_mem_write_en = 1'b0;
          idle_cycle("rnd.end");
        end
      end
      chk_counts("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
